// File: rtl/gpio_core.sv
// GPIO core: 32 pads with synchronized inputs, output/enable registers and per-bit edge interrupts.
// Optional build macro GPIO_BOTHEDGE_EN adds the RGPIO_BOTH any-edge register at address 0x7.
module gpio_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        gpio_we,
    input  logic [3:0]  gpio_addr,
    input  logic [31:0] gpio_dat_i,
    output logic [31:0] gpio_dat_o,
    output logic        gpio_inta_o,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_oe
);

    localparam logic [3:0] ADDR_IN    = 4'h0;
    localparam logic [3:0] ADDR_OUT   = 4'h1;
    localparam logic [3:0] ADDR_OE    = 4'h2;
    localparam logic [3:0] ADDR_INTE  = 4'h3;
    localparam logic [3:0] ADDR_PTRIG = 4'h4;
    localparam logic [3:0] ADDR_CTRL  = 4'h5;
    localparam logic [3:0] ADDR_INTS  = 4'h6;
    localparam logic [3:0] ADDR_BOTH  = 4'h7;

    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] prev_q;
    logic [31:0] out_q, out_d;
    logic [31:0] oe_q, oe_d;
    logic [31:0] inte_q, inte_d;
    logic [31:0] ptrig_q, ptrig_d;
    logic        ctrl_inte_q, ctrl_inte_d;
    logic [31:0] ints_q, ints_d;
    logic        inta_q, inta_d;
    logic [31:0] in_sync, rise, fall, qual, w1c;
`ifdef GPIO_BOTHEDGE_EN
    logic [31:0] both_q, both_d;
`endif

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign rise    = in_sync & ~prev_q;
    assign fall    = ~in_sync & prev_q;
`ifdef GPIO_BOTHEDGE_EN
    assign qual    = (rise & (ptrig_q | both_q)) | (fall & (~ptrig_q | both_q));
`else
    assign qual    = (rise & ptrig_q) | (fall & ~ptrig_q);
`endif

    // NOTE: the synchronizer array is cleared element by element because every flop must reset;
    // a storage-style array would normally be left unreset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= in_sync;
        end
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        out_d       = out_q;
        oe_d        = oe_q;
        inte_d      = inte_q;
        ptrig_d     = ptrig_q;
        ctrl_inte_d = ctrl_inte_q;
        w1c         = '0;
`ifdef GPIO_BOTHEDGE_EN
        both_d      = both_q;
`endif
        if (gpio_we) begin
            case (gpio_addr)
                ADDR_OUT:   out_d       = gpio_dat_i;
                ADDR_OE:    oe_d        = gpio_dat_i;
                ADDR_INTE:  inte_d      = gpio_dat_i;
                ADDR_PTRIG: ptrig_d     = gpio_dat_i;
                ADDR_CTRL:  ctrl_inte_d = gpio_dat_i[0];
                ADDR_INTS:  w1c         = gpio_dat_i;
`ifdef GPIO_BOTHEDGE_EN
                ADDR_BOTH:  both_d      = gpio_dat_i;
`endif
                default: ;
            endcase
        end
        // Set is ORed in after the clear so a same-cycle edge wins over W1C.
        ints_d = (ints_q & ~w1c) | (qual & inte_q);
        inta_d = ctrl_inte_q & (|ints_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_q       <= '0;
            oe_q        <= '0;
            inte_q      <= '0;
            ptrig_q     <= '0;
            ctrl_inte_q <= 1'b0;
            ints_q      <= '0;
            inta_q      <= 1'b0;
`ifdef GPIO_BOTHEDGE_EN
            both_q      <= '0;
`endif
        end else begin
            out_q       <= out_d;
            oe_q        <= oe_d;
            inte_q      <= inte_d;
            ptrig_q     <= ptrig_d;
            ctrl_inte_q <= ctrl_inte_d;
            ints_q      <= ints_d;
            inta_q      <= inta_d;
`ifdef GPIO_BOTHEDGE_EN
            both_q      <= both_d;
`endif
        end
    end

    always_comb begin
        gpio_dat_o = '0;
        case (gpio_addr)
            ADDR_IN:    gpio_dat_o = in_sync;
            ADDR_OUT:   gpio_dat_o = out_q;
            ADDR_OE:    gpio_dat_o = oe_q;
            ADDR_INTE:  gpio_dat_o = inte_q;
            ADDR_PTRIG: gpio_dat_o = ptrig_q;
            ADDR_CTRL:  gpio_dat_o = {30'b0, |ints_q, ctrl_inte_q};
            ADDR_INTS:  gpio_dat_o = ints_q;
`ifdef GPIO_BOTHEDGE_EN
            ADDR_BOTH:  gpio_dat_o = both_q;
`endif
            default:    gpio_dat_o = '0;
        endcase
    end

    assign gpio_out    = out_q;
    assign gpio_oe     = oe_q;
    assign gpio_inta_o = inta_q;

endmodule

// File: tb/tb_gpio_core.sv
// Self-checking bench for gpio_core: register table, hand-written interrupt sequences,
// then randomized traffic against a pad-history reference model.
module tb_gpio_core;

    localparam int S      = 2;
    localparam int PERIOD = 10;
`ifdef GPIO_BOTHEDGE_EN
    localparam bit BOTH_EN = 1'b1;
`else
    localparam bit BOTH_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst, gpio_we, gpio_inta_o;
    logic [3:0]  gpio_addr;
    logic [31:0] gpio_dat_i, gpio_dat_o, gpio_in, gpio_out, gpio_oe;

    gpio_core #(.SYNC_STAGES(S)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .gpio_we     (gpio_we),
        .gpio_addr   (gpio_addr),
        .gpio_dat_i  (gpio_dat_i),
        .gpio_dat_o  (gpio_dat_o),
        .gpio_inta_o (gpio_inta_o),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe)
    );

    always #(PERIOD/2) sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pad samples per clock edge, hist[0] newest.
    logic [31:0] hist [4];
    logic [31:0] m_out, m_oe, m_inte, m_ptrig, m_ints, m_both;
    logic        m_ctrl, m_inta;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'h0: return hist[S-1];
            4'h1: return m_out;
            4'h2: return m_oe;
            4'h3: return m_inte;
            4'h4: return m_ptrig;
            4'h5: return {30'b0, (m_ints != 0), m_ctrl};
            4'h6: return m_ints;
            4'h7: return BOTH_EN ? m_both : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic [3:0] a,
                              input logic [31:0] d, input logic [31:0] pad);
        logic [31:0] sync, prev, qual, clr, nxt_ints;
        if (rst) begin
            {m_out, m_oe, m_inte, m_ptrig, m_ints, m_both} = '0;
            m_ctrl = 1'b0;
            m_inta = 1'b0;
            for (int i = 0; i < 4; i++) hist[i] = '0;
            return;
        end
        sync = hist[S-1];
        prev = hist[S];
        for (int i = 0; i < 32; i++) begin
            bit r, f;
            r = sync[i] && !prev[i];
            f = !sync[i] && prev[i];
            if (BOTH_EN && m_both[i]) qual[i] = r || f;
            else if (m_ptrig[i])      qual[i] = r;
            else                      qual[i] = f;
        end
        clr      = (we && a == 4'h6) ? d : 32'h0;
        nxt_ints = (m_ints & ~clr) | (qual & m_inte);
        m_inta   = m_ctrl && (m_ints != 0);
        if (we) begin
            case (a)
                4'h1: m_out   = d;
                4'h2: m_oe    = d;
                4'h3: m_inte  = d;
                4'h4: m_ptrig = d;
                4'h5: m_ctrl  = d[0];
                4'h7: m_both  = BOTH_EN ? d : 32'h0;
                default: ;
            endcase
        end
        m_ints = nxt_ints;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pad;
    endtask

    task automatic step(input logic rst, input logic we, input logic [3:0] a, input logic [31:0] d);
        sys_rst    = rst;
        gpio_we    = we;
        gpio_addr  = a;
        gpio_dat_i = d;
        @(posedge sys_clk);
        model_edge(rst, we, a, d, gpio_in);
        #1;
        sys_rst = 1'b0;
        gpio_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, gpio_addr, 32'h0);
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
        gpio_addr = a;
        #1;
        check(name, gpio_dat_o, exp);
    endtask

    task automatic chk_outs(input string name);
        check({name, "_out"},  gpio_out,    m_out);
        check({name, "_oe"},   gpio_oe,     m_oe);
        check({name, "_inta"}, gpio_inta_o, {31'b0, m_inta});
    endtask

    function automatic void add(input logic we, input logic [3:0] a, input logic [31:0] d,
                                input logic [31:0] e);
        vec_t v;
        v.we = we; v.addr = a; v.wdat = d; v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        gpio_in = '0;
        step(1'b1, 1'b0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h0);
        check("rst_out",  gpio_out, 32'h0);
        check("rst_oe",   gpio_oe,  32'h0);
        check("rst_inta", {31'b0, gpio_inta_o}, 32'h0);

        for (int a = 0; a < 16; a++) add(1'b0, 4'(a), 32'h0, 32'h0);
        add(1'b1, 4'h1, 32'hABCD_1234, 32'hABCD_1234);
        add(1'b1, 4'h2, 32'hFFFF_0000, 32'hFFFF_0000);
        add(1'b0, 4'h1, 32'h0,         32'hABCD_1234);
        add(1'b1, 4'h0, 32'h1234_5678, 32'h0);
        add(1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0);
        add(1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0);
        add(1'b1, 4'h7, 32'hDEAD_BEEF, BOTH_EN ? 32'hDEAD_BEEF : 32'h0);
        add(1'b1, 4'h7, 32'h0,         32'h0);
        add(1'b1, 4'h5, 32'hFFFF_FFFF, 32'h1);
        add(1'b1, 4'h5, 32'h0,         32'h0);
        add(1'b1, 4'h6, 32'hFFFF_FFFF, 32'h0);
        add(1'b1, 4'h3, 32'h0,         32'h0);
        foreach (tbl[i]) begin
            step(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdat);
            check($sformatf("tbl%0d_rd", i), gpio_dat_o, tbl[i].exp);
            chk_outs($sformatf("tbl%0d", i));
        end
        check("pad_out", gpio_out, 32'hABCD_1234);
        check("pad_oe",  gpio_oe,  32'hFFFF_0000);

        // Rising-edge interrupt on bit 0, then W1C.
        step(1'b0, 1'b1, 4'h3, 32'h1);
        step(1'b0, 1'b1, 4'h4, 32'h1);
        step(1'b0, 1'b1, 4'h5, 32'h1);
        gpio_in = 32'h1;
        idle(1);
        idle(1);
        rd("rise_in_n1", 4'h0, 32'h1);
        rd("rise_ints_n1", 4'h6, 32'h0);
        idle(1);
        rd("rise_ints_n2", 4'h6, 32'h1);
        check("rise_inta_n2", {31'b0, gpio_inta_o}, 32'h0);
        idle(1);
        check("rise_inta_n3", {31'b0, gpio_inta_o}, 32'h1);
        rd("rise_ctrl", 4'h5, 32'h3);
        step(1'b0, 1'b1, 4'h6, 32'h1);
        rd("w1c_ints", 4'h6, 32'h0);
        idle(1);
        check("w1c_inta", {31'b0, gpio_inta_o}, 32'h0);

        // Falling edge on bit 3 collides with W1C: set wins.
        step(1'b0, 1'b1, 4'h3, 32'h8);
        gpio_in = 32'h9;
        idle(3);
        rd("fall_pre_ints", 4'h6, 32'h0);
        gpio_in = 32'h1;
        idle(2);
        step(1'b0, 1'b1, 4'h6, 32'h8);
        rd("collide_ints", 4'h6, 32'h8);
        step(1'b0, 1'b1, 4'h3, 32'h0);
        rd("inte_clr_ints", 4'h6, 32'h8);
        idle(1);
        check("inte_clr_inta", {31'b0, gpio_inta_o}, 32'h1);
        step(1'b0, 1'b1, 4'h5, 32'h0);
        idle(1);
        check("ctrl_clr_inta", {31'b0, gpio_inta_o}, 32'h0);
        step(1'b0, 1'b1, 4'h6, 32'hFFFF_FFFF);
        rd("clr_all_ints", 4'h6, 32'h0);

        // All pads high with interrupts disabled.
        gpio_in = 32'hFFFF_FFFF;
        idle(2);
        rd("allhi_in", 4'h0, 32'hFFFF_FFFF);
        idle(2);
        rd("allhi_ints", 4'h6, 32'h0);

        // Reset wins over a simultaneous write; pads high through release.
        step(1'b1, 1'b1, 4'h1, 32'h5555_5555);
        check("rstwr_out", gpio_out, 32'h0);
        rd("rstwr_in", 4'h0, 32'h0);
        idle(4);
        rd("rel_ints", 4'h6, 32'h0);
        rd("rel_in", 4'h0, 32'hFFFF_FFFF);

`ifdef GPIO_BOTHEDGE_EN
        gpio_in = 32'h0;
        idle(4);
        step(1'b0, 1'b1, 4'h7, 32'h4);
        step(1'b0, 1'b1, 4'h3, 32'h4);
        step(1'b0, 1'b1, 4'h4, 32'h4);
        rd("both_rd", 4'h7, 32'h4);
        gpio_in = 32'h4;
        idle(3);
        rd("both_rise", 4'h6, 32'h4);
        step(1'b0, 1'b1, 4'h6, 32'h4);
        rd("both_clr", 4'h6, 32'h0);
        gpio_in = 32'h0;
        idle(3);
        rd("both_fall", 4'h6, 32'h4);
`else
        step(1'b0, 1'b1, 4'h7, 32'hFFFF_FFFF);
        rd("both_absent", 4'h7, 32'h0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic       rst, we;
            logic [3:0] a, b;
            if ($urandom_range(0, 1) == 0) gpio_in = gpio_in ^ ($urandom() & $urandom());
            rst = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 1) == 0);
            a   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            step(rst, we, a, $urandom());
            check($sformatf("rnd%0d_rd", n), gpio_dat_o, m_read(a));
            chk_outs($sformatf("rnd%0d", n));
            b = 4'($urandom_range(0, 15));
            rd($sformatf("rnd%0d_rd2", n), b, m_read(b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
